pulse_amp_array: RTL and testbench

PULSE_AMP_ARRAY -- requirements
Module: pulse_amp_array

---
 rtl/pulse_amp_pkg.sv | 23 ++
 rtl/pulse_amp_chan.sv | 154 +++++++++++++++
 rtl/pulse_amp_array.sv | 43 ++++
 tb/tb_pulse_amp_array.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_amp_pkg.sv
// Shared definitions for the pulse amplifier array: edge-select codes,
// channel FSM states and a counter-width helper.
package pulse_amp_pkg;

  // edge_sel codes: bit 0 arms the falling edge, bit 1 arms the rising edge
  localparam logic [1:0] EDGE_OFF  = 2'b00;
  localparam logic [1:0] EDGE_FALL = 2'b01;
  localparam logic [1:0] EDGE_RISE = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_DEAD  = 2'd2
  } state_t;

  // Bits needed to hold 0..maxval; never less than one bit so that a
  // zero-length lockout still yields a legal vector.
  function automatic int cnt_width(input int maxval);
    return (maxval < 1) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/pulse_amp_chan.sv
// One pulse channel: optional input synchroniser, AND gate, edge detector
// and the IDLE/PULSE/DEAD one-shot with retrigger and sticky miss flag.
module pulse_amp_chan
  import pulse_amp_pkg::*;
#(
  parameter int NIN  = 3,
  parameter int PW   = 9,
  parameter int DEAD = 0,
  parameter int SYNC = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NIN-1:0] gate,
  input  logic [1:0]     edge_sel,
  input  logic           retrig,
  input  logic           miss_clr,
  output logic           pulse_n,
  output logic           busy,
  output logic           miss
);

  localparam int CW = cnt_width(PW);
  localparam int DW = cnt_width(DEAD);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_END  = CW'(PW);
  localparam logic [DW-1:0] DCNT_ONE = DW'(1);
  localparam logic [DW-1:0] DCNT_END = DW'(DEAD);

  logic [NIN-1:0] gate_s;
  logic           g;
  logic           g_prev_reg;
  logic           primed_reg;
  logic           trig_raw;
  logic           trig;
  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [DW-1:0]  dcnt_reg, dcnt_next;
  logic           miss_set;
  logic           miss_reg;
  logic           pulse_n_reg;
  logic           busy_reg;

  generate
    if (SYNC != 0) begin : g_sync
      logic [NIN-1:0] meta_reg;
      logic [NIN-1:0] sync_reg;
      // two-flop synchroniser on every gate bit
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          meta_reg <= '0;
          sync_reg <= '0;
        end else begin
          meta_reg <= gate;
          sync_reg <= meta_reg;
        end
      end
      assign gate_s = sync_reg;
    end else begin : g_nosync
      assign gate_s = gate;
    end
  endgenerate

  assign g = &gate_s;

  // edge detection against last cycle's level, suppressed until primed
  always_comb begin
    trig_raw = 1'b0;
    case (edge_sel)
      EDGE_FALL: trig_raw = g_prev_reg & ~g;
      EDGE_RISE: trig_raw = ~g_prev_reg & g;
      EDGE_BOTH: trig_raw = g_prev_reg ^ g;
      default:   trig_raw = 1'b0;
    endcase
    trig = primed_reg & trig_raw;
  end

  // one-shot sequencing; a trigger on the final pulse cycle is treated as
  // a trigger during the pulse (reload or miss)
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    dcnt_next  = dcnt_reg;
    miss_set   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (trig) begin
          state_next = ST_PULSE;
          cnt_next   = CNT_ONE;
        end
      end
      ST_PULSE: begin
        if (trig && retrig) begin
          cnt_next = CNT_ONE;
        end else begin
          miss_set = trig;
          if (cnt_reg == CNT_END) begin
            cnt_next = '0;
            if (DEAD == 0) begin
              state_next = ST_IDLE;
            end else begin
              state_next = ST_DEAD;
              dcnt_next  = DCNT_ONE;
            end
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
      end
      ST_DEAD: begin
        miss_set = trig;
        if (dcnt_reg == DCNT_END) begin
          state_next = ST_IDLE;
          dcnt_next  = '0;
        end else begin
          dcnt_next = dcnt_reg + DCNT_ONE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
        dcnt_next  = '0;
      end
    endcase
  end

  // state, counters, history and registered (glitch-free) outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      dcnt_reg    <= '0;
      g_prev_reg  <= 1'b0;
      primed_reg  <= 1'b0;
      miss_reg    <= 1'b0;
      pulse_n_reg <= 1'b1;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      dcnt_reg    <= dcnt_next;
      g_prev_reg  <= g;
      primed_reg  <= 1'b1;
      // a new miss beats a simultaneous clear
      miss_reg    <= miss_set ? 1'b1 : (miss_clr ? 1'b0 : miss_reg);
      pulse_n_reg <= (state_next != ST_PULSE);
      busy_reg    <= (state_next != ST_IDLE);
    end
  end

  assign pulse_n = pulse_n_reg;
  assign busy    = busy_reg;
  assign miss    = miss_reg;

endmodule

// File: rtl/pulse_amp_array.sv
// Array of NCH independent gated one-shot pulse channels.
module pulse_amp_array
  import pulse_amp_pkg::*;
#(
  parameter int NCH  = 2,
  parameter int NIN  = 3,
  parameter int PW   = 9,
  parameter int DEAD = 0,
  parameter int SYNC = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCH*NIN-1:0] gate_in,
  input  logic [2*NCH-1:0]   edge_sel,
  input  logic [NCH-1:0]     retrig,
  input  logic [NCH-1:0]     miss_clr,
  output logic [NCH-1:0]     pulse_n,
  output logic [NCH-1:0]     busy,
  output logic [NCH-1:0]     miss
);

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      pulse_amp_chan #(
        .NIN  (NIN),
        .PW   (PW),
        .DEAD (DEAD),
        .SYNC (SYNC)
      ) u_chan (
        .clk      (clk),
        .rst      (rst),
        .gate     (gate_in[gi*NIN +: NIN]),
        .edge_sel (edge_sel[2*gi +: 2]),
        .retrig   (retrig[gi]),
        .miss_clr (miss_clr[gi]),
        .pulse_n  (pulse_n[gi]),
        .busy     (busy[gi]),
        .miss     (miss[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_pulse_amp_array.sv
// Bench for pulse_amp_array: three instances (plain, lockout DEAD=5,
// synchronised inputs), table-driven scenarios, hand-written reset and
// miss sequences, and random stimulus against a countdown model.
module tb_pulse_amp_array;
  import pulse_amp_pkg::*;

  localparam int NCH = 2;
  localparam int NIN = 3;
  localparam int PW  = 9;
  localparam int NI  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NCH*NIN-1:0] gate   [NI];
  logic [2*NCH-1:0]   esel   [NI];
  logic [NCH-1:0]     retrig [NI];
  logic [NCH-1:0]     mclr   [NI];
  logic [NCH-1:0]     pulse_n[NI];
  logic [NCH-1:0]     busy   [NI];
  logic [NCH-1:0]     miss   [NI];

  pulse_amp_array #(.NCH(NCH), .NIN(NIN), .PW(PW), .DEAD(0), .SYNC(0)) u_dut0 (
    .clk(clk), .rst(rst), .gate_in(gate[0]), .edge_sel(esel[0]), .retrig(retrig[0]),
    .miss_clr(mclr[0]), .pulse_n(pulse_n[0]), .busy(busy[0]), .miss(miss[0]));
  pulse_amp_array #(.NCH(NCH), .NIN(NIN), .PW(PW), .DEAD(5), .SYNC(0)) u_dut1 (
    .clk(clk), .rst(rst), .gate_in(gate[1]), .edge_sel(esel[1]), .retrig(retrig[1]),
    .miss_clr(mclr[1]), .pulse_n(pulse_n[1]), .busy(busy[1]), .miss(miss[1]));
  pulse_amp_array #(.NCH(NCH), .NIN(NIN), .PW(PW), .DEAD(0), .SYNC(1)) u_dut2 (
    .clk(clk), .rst(rst), .gate_in(gate[2]), .edge_sel(esel[2]), .retrig(retrig[2]),
    .miss_clr(mclr[2]), .pulse_n(pulse_n[2]), .busy(busy[2]), .miss(miss[2]));

  int checks;
  int errors;

  // reference model: remaining low cycles and remaining lockout cycles
  int dpar[NI];
  bit spar[NI];
  int mrem [NI][NCH];
  int mdead[NI][NCH];
  bit mmiss[NI][NCH];
  bit mgp  [NI][NCH];
  bit ma1  [NI][NCH];
  bit ma2  [NI][NCH];
  bit mprimed;

  typedef struct {
    int       inst;
    logic [1:0] es;
    bit       rt;
    int       t1, t2, t3;
    int       exp_first;
    int       exp_low;
    bit       exp_miss;
  } vec_t;

  task automatic model_reset();
    for (int i = 0; i < NI; i++)
      for (int c = 0; c < NCH; c++) begin
        mrem[i][c] = 0; mdead[i][c] = 0; mmiss[i][c] = 0;
        mgp[i][c] = 0; ma1[i][c] = 0; ma2[i][c] = 0;
      end
    mprimed = 0;
  endtask

  task automatic model_step();
    for (int i = 0; i < NI; i++)
      for (int c = 0; c < NCH; c++) begin
        bit a, gnow, trig, ev;
        logic [1:0] es;
        a    = &gate[i][c*NIN +: NIN];
        gnow = spar[i] ? ma2[i][c] : a;
        es   = esel[i][2*c +: 2];
        trig = mprimed && ((es[0] && mgp[i][c] && !gnow) || (es[1] && !mgp[i][c] && gnow));
        ev   = 0;
        if (trig && mrem[i][c] == 0 && mdead[i][c] == 0) begin
          mrem[i][c] = PW;
        end else if (mrem[i][c] > 0) begin
          if (trig && retrig[i][c]) mrem[i][c] = PW;
          else begin
            if (trig) ev = 1;
            mrem[i][c]--;
            if (mrem[i][c] == 0) mdead[i][c] = dpar[i];
          end
        end else if (mdead[i][c] > 0) begin
          if (trig) ev = 1;
          mdead[i][c]--;
        end
        if (ev) mmiss[i][c] = 1;
        else if (mclr[i][c]) mmiss[i][c] = 0;
        ma2[i][c] = ma1[i][c];
        ma1[i][c] = a;
        mgp[i][c] = gnow;
      end
    mprimed = 1;
  endtask

  task automatic compare();
    for (int i = 0; i < NI; i++) begin
      logic [NCH-1:0] ep, eb, em;
      for (int c = 0; c < NCH; c++) begin
        ep[c] = (mrem[i][c] == 0);
        eb[c] = (mrem[i][c] > 0) || (mdead[i][c] > 0);
        em[c] = mmiss[i][c];
      end
      checks++;
      if (pulse_n[i] !== ep || busy[i] !== eb || miss[i] !== em) begin
        errors++;
        $display("FAIL model inst%0d t=%0t: pulse_n=%b busy=%b miss=%b required pulse_n=%b busy=%b miss=%b",
                 i, $time, pulse_n[i], busy[i], miss[i], ep, eb, em);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    #1;
    compare();
  endtask

  task automatic idle_all(input int n);
    for (int i = 0; i < NI; i++) begin
      gate[i] = '1; esel[i] = '0; retrig[i] = '0; mclr[i] = '0;
    end
    repeat (n) tick();
    for (int i = 0; i < NI; i++) mclr[i] = '1;
    tick();
    for (int i = 0; i < NI; i++) mclr[i] = '0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int first, low0, low1;
    bit lvl;
    idle_all(25);
    esel[v.inst][1:0] = v.es;
    retrig[v.inst][0] = v.rt;
    lvl = 1; first = -1; low0 = 0; low1 = 0;
    for (int k = 0; k < 40; k++) begin
      if (k == v.t1 || k == v.t2 || k == v.t3) lvl = ~lvl;
      gate[v.inst][2:0] = lvl ? 3'b111 : 3'b011;
      tick();
      if (pulse_n[v.inst][0] == 1'b0) begin
        low0++;
        if (first < 0) first = k;
      end
      if (pulse_n[v.inst][1] == 1'b0) low1++;
    end
    $display("vec %0d inst %0d: first_low=%0d low_cycles=%0d miss=%0b", idx, v.inst, first, low0, miss[v.inst][0]);
    chk($sformatf("vec%0d_first_low", idx), first, v.exp_first);
    chk($sformatf("vec%0d_low_cycles", idx), low0, v.exp_low);
    chk($sformatf("vec%0d_miss", idx), {31'd0, miss[v.inst][0]}, {31'd0, v.exp_miss});
    chk($sformatf("vec%0d_ch1_quiet", idx), low1, 0);
  endtask

  initial begin
    vec_t vecs[11];
    int lc;
    checks = 0; errors = 0;
    dpar = '{0, 5, 0};
    spar = '{0, 0, 1};
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      gate[i] = '1; esel[i] = '0; retrig[i] = '0; mclr[i] = '0;
    end
    model_reset();

    //            inst es     rt  t1  t2  t3  first low miss
    vecs[0]  = '{0, 2'b01, 0,  3, -1, -1,  3,  9, 0};  // single fall
    vecs[1]  = '{0, 2'b01, 1,  3,  5,  7,  3, 13, 0};  // retrigger 4 in
    vecs[2]  = '{0, 2'b01, 0,  3,  5,  7,  3,  9, 1};  // no retrigger -> miss
    vecs[3]  = '{0, 2'b10, 0,  3,  5, -1,  5,  9, 0};  // rising only
    vecs[4]  = '{0, 2'b11, 0,  3, 14, -1,  3, 18, 0};  // both edges, two pulses
    vecs[5]  = '{0, 2'b00, 0,  3,  6, -1, -1,  0, 0};  // off
    vecs[6]  = '{1, 2'b01, 0,  3, 12, 14,  3,  9, 1};  // trigger in lockout
    vecs[7]  = '{1, 2'b01, 0,  3, 12, 18,  3, 18, 0};  // trigger after lockout
    vecs[8]  = '{2, 2'b11, 0,  3, 23, -1,  5, 18, 0};  // synchronised, +2 latency
    vecs[9]  = '{0, 2'b01, 0,  3,  5, 12,  3,  9, 1};  // trigger on last cycle, no retrig
    vecs[10] = '{0, 2'b01, 1,  3,  5, 12,  3, 18, 0};  // trigger on last cycle, retrig

    tick(); tick();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("reset_pulse_n_inst%0d", i), {30'd0, pulse_n[i]}, 32'd3);
      chk($sformatf("reset_busy_inst%0d", i), {30'd0, busy[i]}, 32'd0);
      chk($sformatf("reset_miss_inst%0d", i), {30'd0, miss[i]}, 32'd0);
    end
    rst = 1'b0;

    for (int v = 0; v < 11; v++) run_vec(v, vecs[v]);

    // asynchronous reset three cycles into a pulse, gate held low after
    idle_all(25);
    esel[0][1:0] = EDGE_FALL;
    gate[0][2:0] = 3'b011;
    tick(); tick(); tick();
    chk("pulse_before_rst", {31'd0, pulse_n[0][0]}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pulse_n", {30'd0, pulse_n[0]}, 32'd3);
    chk("async_rst_busy", {30'd0, busy[0]}, 32'd0);
    model_reset();
    tick(); tick();
    rst = 1'b0;
    lc = 0;
    repeat (15) begin tick(); if (pulse_n[0][0] == 1'b0) lc++; end
    $display("seq reset_mid_pulse: low cycles after release=%0d", lc);
    chk("no_pulse_after_rst", lc, 0);

    // gate high through release on a rising-edge channel: no false trigger
    #2 rst = 1'b1;
    model_reset();
    esel[0][1:0] = EDGE_RISE;
    gate[0] = '1;
    tick(); tick();
    rst = 1'b0;
    lc = 0;
    repeat (15) begin tick(); if (pulse_n[0][0] == 1'b0) lc++; end
    $display("seq primed: low cycles after release=%0d", lc);
    chk("no_trigger_first_cycle", lc, 0);

    // miss set and clear in the same cycle, then clear alone
    idle_all(25);
    esel[0][1:0] = EDGE_FALL;
    gate[0][2:0] = 3'b011; tick();
    gate[0][2:0] = 3'b111; tick();
    gate[0][2:0] = 3'b011; mclr[0][0] = 1'b1; tick();
    chk("miss_set_beats_clr", {31'd0, miss[0][0]}, 32'd1);
    tick();
    chk("miss_clr_alone", {31'd0, miss[0][0]}, 32'd0);
    mclr[0] = '0;
    $display("seq miss_clr: done");

    // random traffic on every channel of every instance
    idle_all(25);
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NI; i++) begin
        for (int b = 0; b < NCH*NIN; b++)
          if ($urandom_range(0, 3) == 0) gate[i][b] = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 15) == 0)
          for (int b = 0; b < 2*NCH; b++) esel[i][b] = $urandom_range(0, 1) != 0;
        for (int c = 0; c < NCH; c++) begin
          retrig[i][c] = $urandom_range(0, 1) != 0;
          mclr[i][c]   = $urandom_range(0, 7) == 0;
        end
      end
      tick();
    end
    $display("random: 3000 cycles applied");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
